// File: rtl/drain_pkg.sv
// Shared types and constants for the ofmap drain block.
package drain_pkg;
   typedef enum logic {W_IDLE, W_FILL}   wr_state_t;
   typedef enum logic {R_IDLE, R_STREAM} rd_state_t;

   localparam logic BANK0 = 1'b0;
   localparam logic BANK1 = 1'b1;
endpackage

// File: rtl/sync_dp_ram.sv
// Simple dual-port RAM: port a write-only, port b read-only, registered read.
module sync_dp_ram #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  we_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] wdata_a,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   output logic [DATA_WIDTH-1:0] rdata_b
);
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // Write port.
   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= wdata_a;
   end

   // Read port: data lands one cycle after the address.
   always_ff @(posedge clk) begin
      rdata_b <= mem[addr_b];
   end
endmodule

// File: rtl/ofmap_drain.sv
// Ping-pong row buffer between the PE array results and the downstream stream.
module ofmap_drain
   import drain_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] o_dimension,
   input  logic [ADDR_WIDTH-1:0] chans_per_mem,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  row_done,
   output logic                  layer_done,
   output logic                  cfg_err,
   output logic                  busy
);
   localparam int AW = ADDR_WIDTH;

   // Configuration check is done at full width so oversize products are caught.
   logic [2*AW-1:0] row_len_full;
   logic [2*AW:0]   two_len, depth;
   logic            cfg_ok, arm;
   logic [AW-1:0]   o_dim_q, row_len_q;

   assign row_len_full = {{AW{1'b0}}, o_dimension} * {{AW{1'b0}}, chans_per_mem};
   assign two_len      = {row_len_full, 1'b0};
   assign depth        = {{AW{1'b0}}, 1'b1, {AW{1'b0}}};
   assign cfg_ok       = (|o_dimension) && (|chans_per_mem) && (two_len <= depth);
   assign arm          = start && !busy && cfg_ok;

   // Layer control: config latch, busy and sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0; cfg_err <= 1'b0; o_dim_q <= '0; row_len_q <= '0;
      end else if (start && !busy) begin
         if (cfg_ok) begin
            busy      <= 1'b1;
            cfg_err   <= 1'b0;
            o_dim_q   <= o_dimension;
            row_len_q <= row_len_full[AW-1:0];
         end else begin
            cfg_err <= 1'b1;
         end
      end else if (layer_done) begin
         busy <= 1'b0;
      end
   end

   // ---------------- write side ----------------
   wr_state_t     wr_state, wr_state_nxt;
   logic          wr_bank, wr_bank_nxt;
   logic [AW-1:0] wr_idx, wr_idx_nxt, rows_written, rows_written_nxt, wr_addr;
   logic [1:0]    bank_full, bank_set, bank_clr;
   logic          wr_acc;

   assign in_ready = busy && !bank_full[wr_bank] && (rows_written < o_dim_q);
   assign wr_acc   = valid_in && in_ready;
   assign wr_addr  = ((wr_bank == BANK1) ? row_len_q : '0) + wr_idx;

   // Write FSM register.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state <= W_IDLE; wr_bank <= BANK0; wr_idx <= '0; rows_written <= '0;
      end else begin
         wr_state <= wr_state_nxt; wr_bank <= wr_bank_nxt;
         wr_idx <= wr_idx_nxt; rows_written <= rows_written_nxt;
      end
   end

   // Write FSM next state: fill the current bank, hand it over when the row completes.
   always_comb begin
      wr_state_nxt     = wr_state;
      wr_bank_nxt      = wr_bank;
      wr_idx_nxt       = wr_idx;
      rows_written_nxt = rows_written;
      bank_set         = 2'b00;
      case (wr_state)
         W_IDLE: if (arm) begin
            wr_state_nxt = W_FILL; wr_bank_nxt = BANK0;
            wr_idx_nxt = '0; rows_written_nxt = '0;
         end
         W_FILL: begin
            if (wr_acc) begin
               if (wr_idx == row_len_q - 1'b1) begin
                  bank_set[wr_bank] = 1'b1;
                  wr_bank_nxt       = ~wr_bank;
                  wr_idx_nxt        = '0;
                  rows_written_nxt  = rows_written + 1'b1;
               end else begin
                  wr_idx_nxt = wr_idx + 1'b1;
               end
            end
            if (rows_written_nxt == o_dim_q) wr_state_nxt = W_IDLE;
         end
         default: wr_state_nxt = W_IDLE;
      endcase
   end

   // Bank occupancy; set and clear always target different banks.
   always_ff @(posedge clk) begin
      if (rst || arm) bank_full <= 2'b00;
      else            bank_full <= (bank_full | bank_set) & ~bank_clr;
   end

   // ---------------- read side ----------------
   rd_state_t     rd_state, rd_state_nxt;
   logic          rd_bank, rd_bank_nxt, out_valid_nxt, out_acc;
   logic [AW-1:0] rd_idx, rd_idx_nxt, rows_read, rows_read_nxt;
   logic [AW-1:0] rd_ptr, rd_ptr_next, rd_addr;
   logic [DATA_WIDTH-1:0] ram_q;

   assign rd_ptr      = ((rd_bank == BANK1) ? row_len_q : '0) + rd_idx;
   assign rd_ptr_next = rd_ptr + 1'b1;
   assign out_acc     = out_valid && out_ready;
   // Zero when idle; during a stall the same address is re-read so the word holds.
   assign data_out    = out_valid ? ram_q : '0;

   // Read FSM register.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state <= R_IDLE; rd_bank <= BANK0; rd_idx <= '0;
         rows_read <= '0; out_valid <= 1'b0;
      end else begin
         rd_state <= rd_state_nxt; rd_bank <= rd_bank_nxt; rd_idx <= rd_idx_nxt;
         rows_read <= rows_read_nxt; out_valid <= out_valid_nxt;
      end
   end

   // Read FSM next state: prime the RAM, stream, release banks, chain without bubbles.
   always_comb begin
      rd_state_nxt  = rd_state;
      rd_bank_nxt   = rd_bank;
      rd_idx_nxt    = rd_idx;
      rows_read_nxt = rows_read;
      out_valid_nxt = out_valid;
      rd_addr       = rd_ptr;
      bank_clr      = 2'b00;
      row_done      = 1'b0;
      layer_done    = 1'b0;
      case (rd_state)
         R_IDLE: begin
            out_valid_nxt = 1'b0;
            if (arm) begin
               rd_bank_nxt = BANK0; rd_idx_nxt = '0; rows_read_nxt = '0;
            end else if (busy && bank_full[rd_bank]) begin
               rd_state_nxt = R_STREAM; rd_idx_nxt = '0;
            end
         end
         R_STREAM: begin
            if (!out_valid) begin
               out_valid_nxt = 1'b1;           // first issue of this bank
            end else if (out_acc) begin
               if (rd_idx == row_len_q - 1'b1) begin
                  bank_clr[rd_bank] = 1'b1;
                  row_done          = 1'b1;
                  rows_read_nxt     = rows_read + 1'b1;
                  rd_bank_nxt       = ~rd_bank;
                  rd_idx_nxt        = '0;
                  if (rows_read_nxt == o_dim_q) begin
                     layer_done    = 1'b1;
                     out_valid_nxt = 1'b0;
                     rd_state_nxt  = R_IDLE;
                  end else if (bank_full[~rd_bank]) begin
                     rd_addr = (rd_bank == BANK1) ? '0 : row_len_q;
                  end else begin
                     out_valid_nxt = 1'b0;
                     rd_state_nxt  = R_IDLE;
                  end
               end else begin
                  rd_idx_nxt = rd_idx + 1'b1;
                  rd_addr    = rd_ptr_next;
               end
            end
         end
         default: rd_state_nxt = R_IDLE;
      endcase
   end

   sync_dp_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clk     (clk),
      .we_a    (wr_acc),
      .addr_a  (wr_addr),
      .wdata_a (data_in),
      .addr_b  (rd_addr),
      .rdata_b (ram_q)
   );
endmodule

// File: tb/tb_ofmap_drain.sv
// Randomized bench for ofmap_drain against a word-queue / row-count reference model.
module tb_ofmap_drain;
   localparam int DW = 16;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst, start, valid_in, in_ready, out_valid, out_ready;
   logic          row_done, layer_done, cfg_err, busy;
   logic [AW-1:0] o_dimension, chans_per_mem;
   logic [DW-1:0] data_in, data_out;

   always #5 clk = ~clk;

   ofmap_drain #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .o_dimension(o_dimension),
      .chans_per_mem(chans_per_mem), .data_in(data_in), .valid_in(valid_in),
      .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid),
      .out_ready(out_ready), .row_done(row_done), .layer_done(layer_done),
      .cfg_err(cfg_err), .busy(busy)
   );

   int checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: words leave in exactly the order they were accepted;
   // buffer holds at most two complete rows.
   logic [DW-1:0] exp_q[$];
   int  od_m, rl_m, w_words, w_rows, r_words, r_rows, cyc, first_in, first_out;
   bit  busy_m, cfg_err_m, prev_stall, want_valid;
   logic [DW-1:0] prev_data;

   function automatic void reset_model();
      exp_q.delete();
      od_m = 0; rl_m = 0; w_words = 0; w_rows = 0; r_words = 0; r_rows = 0;
      busy_m = 0; cfg_err_m = 0; prev_stall = 0; want_valid = 0;
      first_in = -1; first_out = -1;
   endfunction

   task automatic chk_zero();
      #1;
      chk("rst_data_out", data_out, 0);   chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);   chk("rst_row_done", row_done, 0);
      chk("rst_layer_done", layer_done, 0);
      chk("rst_busy", busy, 0);           chk("rst_cfg_err", cfg_err, 0);
   endtask

   // One clock: check outputs in the low phase, then apply the edge to the model.
   task automatic tick();
      bit in_acc, out_acc, last_w, both_full, sbusy;
      longint prod;
      #1;
      cyc++;
      chk("busy", busy, busy_m);
      chk("cfg_err", cfg_err, cfg_err_m);
      chk("in_ready", in_ready, busy_m && (w_rows < od_m) && (w_rows - r_rows < 2));
      if (w_rows == r_rows) chk("valid_empty", out_valid, 0);
      if (want_valid) chk("no_bubble", out_valid, 1);
      if (prev_stall) begin
         chk("stall_valid", out_valid, 1);
         chk("stall_data", data_out, prev_data);
      end
      want_valid = 0;
      if (out_valid && first_out < 0) first_out = cyc;
      in_acc  = valid_in && in_ready;
      out_acc = out_valid && out_ready;
      last_w  = 0;
      if (out_acc && rl_m != 0) last_w = ((r_words % rl_m) == rl_m - 1);
      if (out_valid) begin
         if (exp_q.size() == 0) chk("data_unexpected", 1, 0);
         else chk("data", data_out, exp_q[0]);
      end
      chk("row_done", row_done, last_w);
      chk("layer_done", layer_done, last_w && (r_rows + 1 == od_m));
      prev_stall = out_valid && !out_ready;
      prev_data  = data_out;
      both_full  = (w_rows - r_rows == 2);
      sbusy      = busy_m;
      @(posedge clk);
      if (rst) begin
         reset_model();
      end else begin
         if (in_acc) begin
            if (w_words == 0) first_in = cyc;
            exp_q.push_back(data_in);
            w_words++;
            if (w_words % rl_m == 0) w_rows++;
         end
         if (out_acc && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            r_words++;
            if (last_w) begin
               r_rows++;
               if (r_rows == od_m) busy_m = 0;
               else if (both_full) want_valid = 1;
            end
         end
         if (start && !sbusy) begin
            prod = longint'(o_dimension) * longint'(chans_per_mem);
            if (o_dimension != 0 && chans_per_mem != 0 && 2 * prod <= (longint'(1) << AW)) begin
               busy_m = 1; cfg_err_m = 0; od_m = o_dimension; rl_m = int'(prod);
               w_words = 0; w_rows = 0; r_words = 0; r_rows = 0;
               first_in = -1; first_out = -1;
            end else begin
               cfg_err_m = 1;
            end
         end
      end
      @(negedge clk);
   endtask

   // rmode: 0 ready always, 1 ready random 50%, 2 ready low for 'hold' cycles.
   // abort_words >= 0 asserts rst once that many words have been accepted.
   task automatic run_layer(input int od, input int ch, input int vpct,
                            input int rmode, input int hold, input int abort_words);
      int budget;
      o_dimension = AW'(od); chans_per_mem = AW'(ch);
      valid_in = 0; out_ready = 0; start = 1;
      tick();
      start = 0;
      budget = 0;
      while ((busy_m || exp_q.size() != 0) && budget < 4000) begin
         valid_in = ($urandom_range(99) < vpct);
         data_in  = DW'($urandom);
         case (rmode)
            0:       out_ready = 1;
            1:       out_ready = $urandom_range(1);
            default: out_ready = (budget >= hold);
         endcase
         if (rmode == 2 && budget == hold)
            chk("stall_fill", w_words, (2 * rl_m < od_m * rl_m) ? 2 * rl_m : od_m * rl_m);
         if (abort_words >= 0 && w_words == abort_words) begin
            rst = 1;
            tick();
            rst = 0; valid_in = 0; out_ready = 0;
            chk_zero();
            return;
         end
         tick();
         budget++;
      end
      chk("layer_timeout", budget < 4000, 1);
      valid_in = 0;
      if (vpct == 100) chk("latency", first_out - first_in, rl_m + 2);
      tick();
      chk("busy_after", busy, 0);
   endtask

   initial begin
      reset_model();
      cyc = 0;
      rst = 1; start = 0; valid_in = 0; out_ready = 0; data_in = '0;
      o_dimension = '0; chans_per_mem = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 0;
      chk_zero();

      // illegal configurations
      o_dimension = 4; chans_per_mem = 0; start = 1; tick(); start = 0;
      tick();
      chk("cfg_err_chans0", cfg_err, 1); chk("busy_chans0", busy, 0);
      chk("in_ready_chans0", in_ready, 0);
      o_dimension = 256; chans_per_mem = 256; start = 1; tick(); start = 0;
      tick();
      chk("cfg_err_big", cfg_err, 1); chk("busy_big", busy, 0);

      // exact-fit boundary is legal; then reset while armed
      o_dimension = 256; chans_per_mem = 128; start = 1; tick(); start = 0;
      tick();
      chk("boundary_busy", busy, 1); chk("boundary_cfg_err", cfg_err, 0);
      rst = 1; tick(); rst = 0;
      chk_zero();

      run_layer(2, 1, 100, 0, 0, -1);    // basic, checks latency
      run_layer(3, 2, 100, 2, 20, -1);   // long downstream stall
      run_layer(4, 3, 60, 1, 0, -1);     // random both sides
      run_layer(3, 4, 100, 0, 0, -1);    // back-to-back banks
      run_layer(5, 2, 80, 1, 0, -1);
      run_layer(2, 3, 100, 0, 0, 5);     // reset mid row 1
      run_layer(1, 1, 100, 0, 0, -1);    // fresh single-word layer

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
